// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: step states,
// opcodes, ALU function codes, execute classes and the control word layout.
package cpu_ctrl_pkg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 5;
    localparam int ALUOP_W = 4;

    // Step states; the execute steps follow T2 numerically so advancing is +1
    localparam logic [3:0] ST_T0   = 4'd0;
    localparam logic [3:0] ST_T1   = 4'd1;
    localparam logic [3:0] ST_T2   = 4'd2;
    localparam logic [3:0] ST_T3   = 4'd3;
    localparam logic [3:0] ST_T4   = 4'd4;
    localparam logic [3:0] ST_T5   = 4'd5;
    localparam logic [3:0] ST_T6   = 4'd6;
    localparam logic [3:0] ST_T7   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11000;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHRA = 4'd6;
    localparam logic [3:0] ALU_SHL  = 4'd7;
    localparam logic [3:0] ALU_ROR  = 4'd8;
    localparam logic [3:0] ALU_ROL  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;
    localparam logic [3:0] ALU_NEG  = 4'd12;
    localparam logic [3:0] ALU_NOT  = 4'd13;

    // Opcodes grouped by the shape of their execute sequence
    typedef enum logic [3:0] {
        CLS_ALU3, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_LD,
        CLS_LDI, CLS_ST, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    // One bit per datapath control plus the ALU function and the illegal flag
    typedef struct packed {
        logic       pc_out;
        logic       zhi_out;
        logic       zlo_out;
        logic       mdr_out;
        logic       ba_out;
        logic       c_out;
        logic       pc_in;
        logic       mar_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       read;
        logic       write;
        logic       inc_pc;
        logic [3:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        if (op >= OP_ADD && op <= OP_ROL)       return CLS_ALU3;
        else if (op >= OP_ADDI && op <= OP_ORI) return CLS_IMM;
        else if (op == OP_MUL || op == OP_DIV)  return CLS_MULDIV;
        else if (op == OP_NEG || op == OP_NOT)  return CLS_UNARY;
        else if (op == OP_LD)                   return CLS_LD;
        else if (op == OP_LDI)                  return CLS_LDI;
        else if (op == OP_ST)                   return CLS_ST;
        else if (op == OP_NOP)                  return CLS_NOP;
        else if (op == OP_HALT)                 return CLS_HALT;
        else                                    return CLS_ILLEGAL;
    endfunction

    // ALU function used by the opcode's computing step; address math is ADD
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST: return ALU_ADD;
            OP_SUB:                                return ALU_SUB;
            OP_AND, OP_ANDI:                       return ALU_AND;
            OP_OR, OP_ORI:                         return ALU_OR;
            OP_SHR:                                return ALU_SHR;
            OP_SHRA:                               return ALU_SHRA;
            OP_SHL:                                return ALU_SHL;
            OP_ROR:                                return ALU_ROR;
            OP_ROL:                                return ALU_ROL;
            OP_MUL:                                return ALU_MUL;
            OP_DIV:                                return ALU_DIV;
            OP_NEG:                                return ALU_NEG;
            OP_NOT:                                return ALU_NOT;
            default:                               return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational decode of (step state, opcode) into the control word, plus
// the sequencing hints the state register needs: last step, memory wait, halt.
module control_sequencer_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [4:0] opcode,
    output ctrl_t      ctrl,
    output logic       last_step,
    output logic       mem_wait,
    output logic       go_halt
);

    op_class_t cls;
    assign cls = op_class(opcode);

    // Control word for the current step; everything defaults to 0 / PASS
    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        mem_wait  = 1'b0;
        go_halt   = 1'b0;
        case (state)
            ST_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
                ctrl.alu_op = ALU_ADD;
            end
            ST_T1: begin
                ctrl.zlo_out = 1'b1; ctrl.pc_in = 1'b1;
                ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                mem_wait = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            ST_HALT: begin
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                case (cls)
                    CLS_ALU3, CLS_IMM: begin
                        if (state == ST_T3) begin
                            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                        end else if (state == ST_T4) begin
                            ctrl.grc   = (cls == CLS_ALU3);
                            ctrl.r_out = (cls == CLS_ALU3);
                            ctrl.c_out = (cls == CLS_IMM);
                            ctrl.alu_op = alu_code(opcode);
                            ctrl.z_in = 1'b1;
                        end else begin
                            ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                            last_step = 1'b1;
                        end
                    end
                    CLS_MULDIV: begin
                        if (state == ST_T3) begin
                            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                        end else if (state == ST_T4) begin
                            ctrl.grb = 1'b1; ctrl.r_out = 1'b1;
                            ctrl.alu_op = alu_code(opcode); ctrl.z_in = 1'b1;
                        end else if (state == ST_T5) begin
                            ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1;
                        end else begin
                            ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1;
                            last_step = 1'b1;
                        end
                    end
                    CLS_UNARY: begin
                        if (state == ST_T3) begin
                            ctrl.grb = 1'b1; ctrl.r_out = 1'b1;
                            ctrl.alu_op = alu_code(opcode); ctrl.z_in = 1'b1;
                        end else begin
                            ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                            last_step = 1'b1;
                        end
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        if (state == ST_T3) begin
                            ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                        end else if (state == ST_T4) begin
                            ctrl.c_out = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.z_in = 1'b1;
                        end else if (state == ST_T5) begin
                            ctrl.zlo_out = 1'b1;
                            ctrl.gra    = (cls == CLS_LDI);
                            ctrl.r_in   = (cls == CLS_LDI);
                            ctrl.mar_in = (cls != CLS_LDI);
                            last_step   = (cls == CLS_LDI);
                        end else if (state == ST_T6) begin
                            ctrl.mdr_in = 1'b1;
                            ctrl.read   = (cls == CLS_LD);
                            mem_wait    = (cls == CLS_LD);
                            ctrl.gra    = (cls == CLS_ST);
                            ctrl.r_out  = (cls == CLS_ST);
                        end else begin
                            ctrl.mdr_out = (cls == CLS_LD);
                            ctrl.gra     = (cls == CLS_LD);
                            ctrl.r_in    = (cls == CLS_LD);
                            ctrl.write   = (cls == CLS_ST);
                            mem_wait     = (cls == CLS_ST);
                            last_step    = 1'b1;
                        end
                    end
                    CLS_HALT: begin
                        go_halt = 1'b1;
                    end
                    CLS_ILLEGAL: begin
                        ctrl.illegal_op = 1'b1;
                        last_step = 1'b1;
                    end
                    default: begin
                        last_step = 1'b1;
                    end
                endcase
            end
            default: begin
                last_step = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: step state register, next-step logic and the
// reset-gated control outputs driving the 32-bit datapath.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] IR,
    input  logic              MemReady,
    input  logic              Stop,
    output logic PCout, output logic ZHIout, output logic ZLOout,
    output logic MDRout, output logic BAout, output logic Cout,
    output logic PCin, output logic MARin, output logic MDRin, output logic IRin,
    output logic Yin, output logic Zin, output logic HIin, output logic LOin,
    output logic Gra, output logic Grb, output logic Grc, output logic Rin, output logic Rout,
    output logic Read, output logic Write, output logic IncPC,
    output logic [ALUOP_W-1:0] AluOp,
    output logic              Run,
    output logic              IllegalOp,
    output logic [3:0]        dbg_state
);

    logic [3:0] state, state_nx;
    ctrl_t      ctrl, ctrl_g;
    logic       last_step, mem_wait, go_halt;
    logic       unused_ir;

    assign unused_ir = ^IR[DATA_W-OP_W-1:0];

    control_sequencer_decode u_decode (
        .state     (state),
        .opcode    (IR[DATA_W-1:DATA_W-OP_W]),
        .ctrl      (ctrl),
        .last_step (last_step),
        .mem_wait  (mem_wait),
        .go_halt   (go_halt)
    );

    // Next step: memory steps hold until MemReady, Stop is honoured only on leaving the last step
    always_comb begin
        state_nx = state;
        case (state)
            ST_T0:   state_nx = ST_T1;
            ST_T1:   state_nx = MemReady ? ST_T2 : ST_T1;
            ST_T2:   state_nx = ST_T3;
            ST_HALT: state_nx = ST_HALT;
            default: begin
                if (go_halt)                 state_nx = ST_HALT;
                else if (mem_wait && !MemReady) state_nx = state;
                else if (last_step)          state_nx = Stop ? ST_HALT : ST_T0;
                else                         state_nx = state + 4'd1;
            end
        endcase
    end

    // Step register; reset abandons any instruction and restarts fetch
    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_T0;
        else       state <= state_nx;
    end

    // All controls are forced low while Reset is held
    always_comb begin
        ctrl_g = Reset ? '0 : ctrl;
    end

    assign {PCout, ZHIout, ZLOout, MDRout, BAout, Cout} =
        {ctrl_g.pc_out, ctrl_g.zhi_out, ctrl_g.zlo_out, ctrl_g.mdr_out, ctrl_g.ba_out, ctrl_g.c_out};
    assign {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin} =
        {ctrl_g.pc_in, ctrl_g.mar_in, ctrl_g.mdr_in, ctrl_g.ir_in,
         ctrl_g.y_in, ctrl_g.z_in, ctrl_g.hi_in, ctrl_g.lo_in};
    assign {Gra, Grb, Grc, Rin, Rout} =
        {ctrl_g.gra, ctrl_g.grb, ctrl_g.grc, ctrl_g.r_in, ctrl_g.r_out};
    assign {Read, Write, IncPC} = {ctrl_g.read, ctrl_g.write, ctrl_g.inc_pc};
    assign AluOp     = ctrl_g.alu_op;
    assign IllegalOp = ctrl_g.illegal_op;
    assign Run       = !Reset && (state != ST_HALT);
    assign dbg_state = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. Each cycle's expected
// {state, controls, AluOp, IllegalOp, Run} word is queued together with the
// inputs to apply in that cycle, then compared against the DUT at negedge.
module tb_control_sequencer;

    localparam logic [3:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4;
    localparam logic [3:0] T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, HALT = 4'd8;

    localparam logic [21:0] S_PCOUT = 22'd1 << 21, S_ZHIOUT = 22'd1 << 20;
    localparam logic [21:0] S_ZLOOUT = 22'd1 << 19, S_MDROUT = 22'd1 << 18;
    localparam logic [21:0] S_BAOUT = 22'd1 << 17, S_COUT = 22'd1 << 16;
    localparam logic [21:0] S_PCIN = 22'd1 << 15, S_MARIN = 22'd1 << 14;
    localparam logic [21:0] S_MDRIN = 22'd1 << 13, S_IRIN = 22'd1 << 12;
    localparam logic [21:0] S_YIN = 22'd1 << 11, S_ZIN = 22'd1 << 10;
    localparam logic [21:0] S_HIIN = 22'd1 << 9, S_LOIN = 22'd1 << 8;
    localparam logic [21:0] S_GRA = 22'd1 << 7, S_GRB = 22'd1 << 6, S_GRC = 22'd1 << 5;
    localparam logic [21:0] S_RIN = 22'd1 << 4, S_ROUT = 22'd1 << 3;
    localparam logic [21:0] S_READ = 22'd1 << 2, S_WRITE = 22'd1 << 1, S_INCPC = 22'd1;

    localparam logic [3:0] A_PASS = 4'd0, A_ADD = 4'd1;

    // clock / reset
    logic Clock, Reset, MemReady, Stop;
    logic [31:0] IR;
    logic PCout, ZHIout, ZLOout, MDRout, BAout, Cout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout, Read, Write, IncPC;
    logic [3:0] AluOp, dbg_state;
    logic Run, IllegalOp;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .MemReady(MemReady), .Stop(Stop),
        .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout), .MDRout(MDRout),
        .BAout(BAout), .Cout(Cout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .Read(Read), .Write(Write), .IncPC(IncPC), .AluOp(AluOp),
        .Run(Run), .IllegalOp(IllegalOp), .dbg_state(dbg_state)
    );

    // scoreboard
    logic [31:0] exp_q[$];
    logic        mr_q[$];
    logic        stop_q[$];
    logic        rst_q[$];
    logic [3:0]  alu_of[32];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got state=%0d ctl=%h alu=%0d ill=%0b run=%0b, want state=%0d ctl=%h alu=%0d ill=%0b run=%0b",
                      tag, obs[31:28], obs[27:6], obs[5:2], obs[1], obs[0],
                      exp[31:28], exp[27:6], exp[5:2], exp[1], exp[0]);
    endtask

    // driver tasks
    task automatic push(input logic [3:0] st, input logic [21:0] sig, input logic [3:0] alu,
                        input logic ill, input logic mr, input logic stp, input logic rst);
        logic run;
        run = !rst && (st != HALT);
        if (rst) begin
            sig = '0; alu = A_PASS; ill = 1'b0;
        end
        exp_q.push_back({st, sig, alu, ill, run});
        mr_q.push_back(mr);
        stop_q.push_back(stp);
        rst_q.push_back(rst);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_fetch(input int t1_wait, input logic stp);
        push(T0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, A_ADD, 1'b0, rnd_bit(), stp, 1'b0);
        for (int i = 0; i < t1_wait; i++)
            push(T1, S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, A_PASS, 1'b0, 1'b0, stp, 1'b0);
        push(T1, S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, A_PASS, 1'b0, 1'b1, stp, 1'b0);
        push(T2, S_MDROUT | S_IRIN, A_PASS, 1'b0, rnd_bit(), stp, 1'b0);
    endtask

    // stop_mode: 0 no Stop, 1 Stop held throughout (halts), 2 Stop on all but the last step
    task automatic run_instr(input logic [31:0] ir, input int t1_wait, input int mem_wait,
                             input int stop_mode);
        logic [4:0] op;
        logic se, sl;
        IR = ir;
        op = ir[31:27];
        se = (stop_mode != 0);
        sl = (stop_mode == 1);
        push_fetch(t1_wait, se);
        if (op >= 5'd3 && op <= 5'd14) begin
            push(T3, S_GRB | S_ROUT | S_YIN, A_PASS, 1'b0, rnd_bit(), se, 1'b0);
            if (op <= 5'd11) push(T4, S_GRC | S_ROUT | S_ZIN, alu_of[op], 1'b0, rnd_bit(), se, 1'b0);
            else             push(T4, S_COUT | S_ZIN, alu_of[op], 1'b0, rnd_bit(), se, 1'b0);
            push(T5, S_ZLOOUT | S_GRA | S_RIN, A_PASS, 1'b0, rnd_bit(), sl, 1'b0);
        end else if (op == 5'd15 || op == 5'd16) begin
            push(T3, S_GRA | S_ROUT | S_YIN, A_PASS, 1'b0, rnd_bit(), se, 1'b0);
            push(T4, S_GRB | S_ROUT | S_ZIN, alu_of[op], 1'b0, rnd_bit(), se, 1'b0);
            push(T5, S_ZLOOUT | S_LOIN, A_PASS, 1'b0, rnd_bit(), se, 1'b0);
            push(T6, S_ZHIOUT | S_HIIN, A_PASS, 1'b0, rnd_bit(), sl, 1'b0);
        end else if (op == 5'd17 || op == 5'd18) begin
            push(T3, S_GRB | S_ROUT | S_ZIN, alu_of[op], 1'b0, rnd_bit(), se, 1'b0);
            push(T4, S_ZLOOUT | S_GRA | S_RIN, A_PASS, 1'b0, rnd_bit(), sl, 1'b0);
        end else if (op <= 5'd2) begin
            push(T3, S_GRB | S_BAOUT | S_YIN, A_PASS, 1'b0, rnd_bit(), se, 1'b0);
            push(T4, S_COUT | S_ZIN, A_ADD, 1'b0, rnd_bit(), se, 1'b0);
            if (op == 5'd1) begin
                push(T5, S_ZLOOUT | S_GRA | S_RIN, A_PASS, 1'b0, rnd_bit(), sl, 1'b0);
            end else begin
                push(T5, S_ZLOOUT | S_MARIN, A_PASS, 1'b0, rnd_bit(), se, 1'b0);
                if (op == 5'd0) begin
                    for (int i = 0; i < mem_wait; i++)
                        push(T6, S_READ | S_MDRIN, A_PASS, 1'b0, 1'b0, se, 1'b0);
                    push(T6, S_READ | S_MDRIN, A_PASS, 1'b0, 1'b1, se, 1'b0);
                    push(T7, S_MDROUT | S_GRA | S_RIN, A_PASS, 1'b0, rnd_bit(), sl, 1'b0);
                end else begin
                    push(T6, S_GRA | S_ROUT | S_MDRIN, A_PASS, 1'b0, rnd_bit(), se, 1'b0);
                    for (int i = 0; i < mem_wait; i++)
                        push(T7, S_WRITE, A_PASS, 1'b0, 1'b0, sl, 1'b0);
                    push(T7, S_WRITE, A_PASS, 1'b0, 1'b1, sl, 1'b0);
                end
            end
        end else if (op == 5'd19) begin
            push(T3, '0, A_PASS, 1'b0, rnd_bit(), se, 1'b0);
        end else begin
            push(T3, '0, A_PASS, (op != 5'd24), rnd_bit(), sl, 1'b0);
        end
    endtask

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++) push(HALT, '0, A_PASS, 1'b0, rnd_bit(), rnd_bit(), 1'b0);
    endtask

    // Apply each queued cycle's inputs, compare at negedge, advance one clock
    task automatic drain(input string tag);
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            MemReady = mr_q.pop_front();
            Stop     = stop_q.pop_front();
            Reset    = rst_q.pop_front();
            if (exp_q[0][31:28] == HALT) IR = $urandom();
            @(negedge Clock);
            obs = {dbg_state, PCout, ZHIout, ZLOout, MDRout, BAout, Cout,
                   PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
                   Gra, Grb, Grc, Rin, Rout, Read, Write, IncPC,
                   AluOp, IllegalOp, Run};
            check(tag, obs, exp_q.pop_front());
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        logic [4:0] op;
        for (int i = 0; i < 32; i++) alu_of[i] = A_PASS;
        alu_of[3] = 4'd1;  alu_of[4] = 4'd2;  alu_of[5] = 4'd3;  alu_of[6] = 4'd4;
        alu_of[7] = 4'd5;  alu_of[8] = 4'd6;  alu_of[9] = 4'd7;  alu_of[10] = 4'd8;
        alu_of[11] = 4'd9; alu_of[12] = 4'd1; alu_of[13] = 4'd3; alu_of[14] = 4'd4;
        alu_of[15] = 4'd10; alu_of[16] = 4'd11; alu_of[17] = 4'd12; alu_of[18] = 4'd13;

        Reset = 1'b1; MemReady = 1'b0; Stop = 1'b0; IR = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        push(T0, '0, A_PASS, 1'b0, 1'b1, 1'b0, 1'b1);
        push(T0, '0, A_PASS, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("reset");

        run_instr(32'h28918000, 0, 0, 0); drain("and");
        run_instr(32'h00900055, 0, 3, 0); drain("ld_wait");
        run_instr(32'h7A280000, 0, 0, 0); drain("mul");
        run_instr(32'h60900007, 2, 0, 0); drain("addi_t1wait");
        run_instr(32'h88900000, 0, 0, 0); drain("neg");
        run_instr(32'h08900044, 0, 0, 0); drain("ldi");
        run_instr(32'h10900055, 1, 2, 2); drain("st_wait_stop_early");
        run_instr(32'hC0000000, 0, 0, 0); drain("nop");
        run_instr(32'hF8000000, 0, 0, 0); drain("illegal");
        run_instr(32'hA0000000, 0, 0, 0); drain("illegal_10100");
        for (int k = 0; k < 6; k++) begin
            op = 5'($urandom_range(3, 18));
            run_instr({op, 27'($urandom())}, $urandom_range(0, 2), 0, 0);
            drain("random_op");
        end

        // reset in T4 of st abandons it; fetch restarts
        IR = 32'h10900055;
        push_fetch(0, 1'b0);
        push(T3, S_GRB | S_BAOUT | S_YIN, A_PASS, 1'b0, 1'b1, 1'b0, 1'b0);
        push(T4, '0, A_PASS, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("st_reset_t4");
        run_instr(32'h18918000, 0, 0, 1); drain("add_stop");
        push_halt(5); drain("halt_idle");
        push(HALT, '0, A_PASS, 1'b0, 1'b0, 1'b0, 1'b1); drain("halt_reset");
        run_instr(32'h98000000, 0, 0, 0);
        push_halt(3); drain("halt_op");
        push(HALT, '0, A_PASS, 1'b0, 1'b0, 1'b0, 1'b1);
        push(T0, '0, A_PASS, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("final_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
